// File: rtl/mem_source_if.sv
// Bus bundle for mem_source: start/length control, sample-memory read port,
// FIFO write port and status.
interface mem_source_if #(
    parameter int ADDR_WIDTH   = 7,
    parameter int DATA_WIDTH   = 32,
    parameter int CONFIG_WIDTH = 32
);
    logic                    start_i;
    logic [CONFIG_WIDTH-1:0] ilen;
    logic [ADDR_WIDTH-1:0]   mem_addr_o;
    logic                    mem_rd_en_o;
    logic [DATA_WIDTH-1:0]   mem_data_i;
    logic                    Full_i;
    logic                    Write_Enable_o;
    logic [DATA_WIDTH-1:0]   fifo_data_o;
    logic                    busy_o;
    logic                    done;

    modport master (
        output start_i, ilen, mem_data_i, Full_i,
        input  mem_addr_o, mem_rd_en_o, Write_Enable_o, fifo_data_o, busy_o, done
    );

    modport slave (
        input  start_i, ilen, mem_data_i, Full_i,
        output mem_addr_o, mem_rd_en_o, Write_Enable_o, fifo_data_o, busy_o, done
    );
endinterface

// File: rtl/mem_source.sv
// Memory-to-FIFO source engine: streams ilen words from a synchronous-read
// memory into a FIFO through a 2-entry holding buffer that hides read latency.
module mem_source #(
    parameter int ADDR_WIDTH   = 7,
    parameter int DATA_WIDTH   = 32,
    parameter int CONFIG_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    mem_source_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state;
    logic [CONFIG_WIDTH-1:0] ilen_q, rd_cnt, wr_cnt, wr_cnt_next;
    logic [DATA_WIDTH-1:0]   hold_q [2];
    logic                    hd;
    logic [1:0]              occ;
    logic                    inflight;
    logic                    busy_q, done_q;
    logic                    wr, issue;

    // An issue is allowed only if the word it returns is guaranteed a slot,
    // counting the word already in flight and any pop this cycle.
    always_comb begin
        wr          = (occ != 2'd0) && !bus.Full_i;
        wr_cnt_next = wr_cnt + CONFIG_WIDTH'(wr);
        issue       = (state == RUN) && (rd_cnt < ilen_q) &&
                      (({1'b0, occ} + {2'b0, inflight} - {2'b0, wr}) < 3'd2);
    end

    assign bus.mem_rd_en_o    = issue;
    assign bus.mem_addr_o     = rd_cnt[ADDR_WIDTH-1:0];
    assign bus.Write_Enable_o = wr;
    assign bus.fifo_data_o    = hold_q[hd];
    assign bus.busy_o         = busy_q;
    assign bus.done           = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ilen_q    <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            hold_q[0] <= '0;
            hold_q[1] <= '0;
            hd        <= 1'b0;
            occ       <= 2'd0;
            inflight  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Tail slot sits just past the live entries; capture and pop may coincide.
            if (inflight) hold_q[hd ^ occ[0]] <= bus.mem_data_i;
            if (wr) begin
                hd     <= ~hd;
                wr_cnt <= wr_cnt_next;
            end
            occ      <= occ + {1'b0, inflight} - {1'b0, wr};
            inflight <= issue;
            if (issue) rd_cnt <= rd_cnt + CONFIG_WIDTH'(1);

            case (state)
                IDLE: if (bus.start_i) begin
                    ilen_q    <= bus.ilen;
                    rd_cnt    <= '0;
                    wr_cnt    <= '0;
                    hold_q[0] <= '0;
                    hold_q[1] <= '0;
                    hd        <= 1'b0;
                    occ       <= 2'd0;
                    inflight  <= 1'b0;
                    busy_q    <= 1'b1;
                    state     <= RUN;
                end
                RUN:   if (rd_cnt == ilen_q) state <= DRAIN;
                DRAIN: if (wr_cnt_next == ilen_q) begin
                    state  <= DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
